// File: rtl/multi_alarm_clock_pkg.sv
// Shared types and helpers for the multi-alarm clock: BCD time, FSM states,
// validation and minute-increment arithmetic.
package multi_alarm_clock_pkg;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [2:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_t;

  function automatic logic bcd_valid(input bcd_time_t t);
    logic hours_ok;
    hours_ok = (t.h1 < 2'd2) || ((t.h1 == 2'd2) && (t.h0 <= 4'd3));
    return hours_ok && (t.h0 <= 4'd9) && (t.m1 <= 3'd5) && (t.m0 <= 4'd9);
  endfunction

  function automatic logic time_eq(input bcd_time_t a, input bcd_time_t b);
    return (a == b);
  endfunction

  // One-minute step with BCD carries; 23:59 wraps to 00:00.
  function automatic bcd_time_t bcd_increment(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.m0 != 4'd9) begin
      n.m0 = t.m0 + 4'd1;
    end else begin
      n.m0 = 4'd0;
      if (t.m1 != 3'd5) begin
        n.m1 = t.m1 + 3'd1;
      end else begin
        n.m1 = 3'd0;
        if ((t.h1 == 2'd2) && (t.h0 == 4'd3)) begin
          n.h1 = 2'd0;
          n.h0 = 4'd0;
        end else if (t.h0 == 4'd9) begin
          n.h0 = 4'd0;
          n.h1 = t.h1 + 2'd1;
        end else begin
          n.h0 = t.h0 + 4'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/multi_alarm_clock_counter.sv
// Prescaler plus BCD HH:MM timekeeper. next_time/minute_tick are combinational
// so the parent can match alarms on the same edge the time advances.
module bcd_time_counter
  import multi_alarm_clock_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      enable,
  input  logic      set_time,
  input  bcd_time_t load_time,
  output bcd_time_t cur_time,
  output bcd_time_t next_time,
  output logic      minute_tick,
  output logic      load_err
);

  localparam int CW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

  logic [CW-1:0] presc_reg, presc_next;
  bcd_time_t     time_reg, time_next;
  logic          load_ok;
  logic          presc_last;

  always_comb begin
    load_ok     = set_time && bcd_valid(load_time);
    load_err    = set_time && !bcd_valid(load_time);
    presc_last  = (presc_reg == CW'(TICKS_PER_MIN - 1));
    // An accepted load takes priority over a coinciding minute advance.
    minute_tick = enable && presc_last && !load_ok;
    presc_next  = presc_reg;
    time_next   = time_reg;
    if (load_ok) begin
      presc_next = '0;
      time_next  = load_time;
    end else if (enable) begin
      if (presc_last) begin
        presc_next = '0;
        time_next  = bcd_increment(time_reg);
      end else begin
        presc_next = presc_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_reg <= '0;
      time_reg  <= '0;
    end else begin
      presc_reg <= presc_next;
      time_reg  <= time_next;
    end
  end

  assign cur_time  = time_reg;
  assign next_time = time_next;

endmodule

// File: rtl/multi_alarm_clock.sv
// Multi-slot alarm clock: alarm table, ring/snooze FSM and tone divider around
// the BCD timekeeper.
module multi_alarm_clock
  import multi_alarm_clock_pkg::*;
#(
  parameter int NUM_ALARMS    = 4,
  parameter int TICKS_PER_MIN = 60,
  parameter int SNOOZE_MIN    = 5,
  parameter int RING_MIN      = 3,
  parameter int TONE_DIV      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  set_time,
  input  logic [1:0]            t_h1,
  input  logic [3:0]            t_h0,
  input  logic [2:0]            t_m1,
  input  logic [3:0]            t_m0,
  input  logic                  alarm_wr,
  input  logic [2:0]            alarm_idx,
  input  logic [1:0]            a_h1,
  input  logic [3:0]            a_h0,
  input  logic [2:0]            a_m1,
  input  logic [3:0]            a_m0,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [1:0]            hO1,
  output logic [3:0]            hO0,
  output logic [2:0]            mO1,
  output logic [3:0]            mO0,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  snoozed,
  output logic                  set_err,
  output logic                  speaker
);

  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  bcd_time_t cur_time, next_time, wr_time;
  logic      minute_tick, load_err;
  logic      wr_hit, wr_ok, wr_err;

  bcd_time_counter #(.TICKS_PER_MIN(TICKS_PER_MIN)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .set_time   (set_time),
    .load_time  ({t_h1, t_h0, t_m1, t_m0}),
    .cur_time   (cur_time),
    .next_time  (next_time),
    .minute_tick(minute_tick),
    .load_err   (load_err)
  );

  bcd_time_t alarm_reg [NUM_ALARMS];

  assign wr_time = {a_h1, a_h0, a_m1, a_m0};
  assign wr_hit  = alarm_wr && (int'(alarm_idx) < NUM_ALARMS);
  assign wr_ok   = wr_hit && bcd_valid(wr_time);
  assign wr_err  = wr_hit && !bcd_valid(wr_time);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) alarm_reg[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++)
        if (alarm_idx == 3'(i)) alarm_reg[i] <= wr_time;
    end
  end

  // Matches only fire on a real minute advance, never on a load.
  logic [NUM_ALARMS-1:0] match;
  generate
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_match
      assign match[gi] = minute_tick && alarm_en[gi] && time_eq(alarm_reg[gi], next_time);
    end
  endgenerate

  alarm_state_t          state_reg, state_next;
  logic [NUM_ALARMS-1:0] ring_reg, ring_next, mask_reg, mask_next;
  logic [NUM_ALARMS-1:0] ring_live, mask_live;
  logic [5:0]            ring_cnt_reg, ring_cnt_next, snz_cnt_reg, snz_cnt_next;
  logic [TW-1:0]         tone_cnt_reg, tone_cnt_next;
  logic                  speaker_reg, speaker_next, set_err_reg;

  always_comb begin
    state_next    = state_reg;
    ring_next     = ring_reg;
    mask_next     = mask_reg;
    ring_cnt_next = ring_cnt_reg;
    snz_cnt_next  = snz_cnt_reg;
    ring_live     = (ring_reg & alarm_en) | match;
    mask_live     = mask_reg & alarm_en;
    case (state_reg)
      ST_IDLE: begin
        if (|match) begin
          state_next    = ST_RING;
          ring_next     = match;
          ring_cnt_next = '0;
        end
      end
      ST_RING: begin
        if (dismiss) begin
          state_next = ST_IDLE;
          ring_next  = '0;
        end else if (snooze) begin
          state_next   = (|ring_live) ? ST_SNOOZE : ST_IDLE;
          mask_next    = ring_live;
          ring_next    = '0;
          snz_cnt_next = '0;
        end else if (!(|ring_live)) begin
          state_next = ST_IDLE;
          ring_next  = '0;
        end else if (minute_tick && (ring_cnt_reg == 6'(RING_MIN - 1))) begin
          // A fresh match on the timeout minute restarts the ring period.
          if (|match) begin
            ring_next     = ring_live;
            ring_cnt_next = '0;
          end else begin
            state_next = ST_IDLE;
            ring_next  = '0;
          end
        end else begin
          ring_next = ring_live;
          if (minute_tick) ring_cnt_next = ring_cnt_reg + 6'd1;
        end
      end
      ST_SNOOZE: begin
        if (dismiss) begin
          state_next = ST_IDLE;
          mask_next  = '0;
        end else if (|match) begin
          state_next    = ST_RING;
          ring_next     = mask_live | match;
          mask_next     = '0;
          ring_cnt_next = '0;
        end else if (!(|mask_live)) begin
          state_next = ST_IDLE;
          mask_next  = '0;
        end else if (minute_tick && (snz_cnt_reg == 6'(SNOOZE_MIN - 1))) begin
          state_next    = ST_RING;
          ring_next     = mask_live;
          mask_next     = '0;
          ring_cnt_next = '0;
        end else begin
          mask_next = mask_live;
          if (minute_tick) snz_cnt_next = snz_cnt_reg + 6'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        ring_next  = '0;
        mask_next  = '0;
      end
    endcase
  end

  // Tone restarts low on every RING entry; any other state silences it.
  always_comb begin
    tone_cnt_next = '0;
    speaker_next  = 1'b0;
    if ((state_reg == ST_RING) && (state_next == ST_RING)) begin
      if (tone_cnt_reg == TW'(TONE_DIV - 1)) begin
        speaker_next = ~speaker_reg;
      end else begin
        tone_cnt_next = tone_cnt_reg + TW'(1);
        speaker_next  = speaker_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      ring_reg     <= '0;
      mask_reg     <= '0;
      ring_cnt_reg <= '0;
      snz_cnt_reg  <= '0;
      tone_cnt_reg <= '0;
      speaker_reg  <= 1'b0;
      set_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ring_reg     <= ring_next;
      mask_reg     <= mask_next;
      ring_cnt_reg <= ring_cnt_next;
      snz_cnt_reg  <= snz_cnt_next;
      tone_cnt_reg <= tone_cnt_next;
      speaker_reg  <= speaker_next;
      set_err_reg  <= load_err || wr_err;
    end
  end

  assign hO1     = cur_time.h1;
  assign hO0     = cur_time.h0;
  assign mO1     = cur_time.m1;
  assign mO0     = cur_time.m0;
  assign ringing = ring_reg;
  assign snoozed = (state_reg == ST_SNOOZE);
  assign set_err = set_err_reg;
  assign speaker = speaker_reg;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench for multi_alarm_clock: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_multi_alarm_clock;

  logic       clk = 1'b0;
  logic       reset, enable, set_time, alarm_wr, snooze, dismiss;
  logic [1:0] t_h1, a_h1;
  logic [3:0] t_h0, t_m0, a_h0, a_m0;
  logic [2:0] t_m1, a_m1, alarm_idx;
  logic [3:0] alarm_en;
  logic [1:0] hO1;
  logic [3:0] hO0, mO0;
  logic [2:0] mO1;
  logic [3:0] ringing;
  logic       snoozed, set_err, speaker;

  multi_alarm_clock #(
    .NUM_ALARMS(4), .TICKS_PER_MIN(2), .SNOOZE_MIN(5), .RING_MIN(3), .TONE_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .set_time(set_time),
    .t_h1(t_h1), .t_h0(t_h0), .t_m1(t_m1), .t_m0(t_m0),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx),
    .a_h1(a_h1), .a_h0(a_h0), .a_m1(a_m1), .a_m0(a_m0),
    .alarm_en(alarm_en), .snooze(snooze), .dismiss(dismiss),
    .hO1(hO1), .hO0(hO0), .mO1(mO1), .mO0(mO0),
    .ringing(ringing), .snoozed(snoozed), .set_err(set_err), .speaker(speaker)
  );

  always #5 clk = ~clk;

  // Field-select bits for an expectation.
  localparam bit [4:0] MT = 5'b00001, MR = 5'b00010, MS = 5'b00100, ME = 5'b01000, MK = 5'b10000;

  typedef struct {
    string      name;
    bit [4:0]   m;
    logic [12:0] t;
    logic [3:0] r;
    logic       s;
    logic       e;
    logic       k;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [12:0] tm(input int hh, input int mm);
    return {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic chk(input string name, input bit [4:0] m, input logic [12:0] t,
                     input logic [3:0] r, input logic s, input logic e, input logic k);
    exp_t x;
    x.name = name; x.m = m; x.t = t; x.r = r; x.s = s; x.e = e; x.k = k;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t x;
      logic [12:0] cur;
      x   = sb.pop_front();
      cur = {hO1, hO0, mO1, mO0};
      if (x.m[0]) begin
        total++;
        if (cur !== x.t) begin bad++; $display("FAIL %s: time got=%h want=%h", x.name, cur, x.t); end
      end
      if (x.m[1]) begin
        total++;
        if (ringing !== x.r) begin bad++; $display("FAIL %s: ringing got=%b want=%b", x.name, ringing, x.r); end
      end
      if (x.m[2]) begin
        total++;
        if (snoozed !== x.s) begin bad++; $display("FAIL %s: snoozed got=%b want=%b", x.name, snoozed, x.s); end
      end
      if (x.m[3]) begin
        total++;
        if (set_err !== x.e) begin bad++; $display("FAIL %s: set_err got=%b want=%b", x.name, set_err, x.e); end
      end
      if (x.m[4]) begin
        total++;
        if (speaker !== x.k) begin bad++; $display("FAIL %s: speaker got=%b want=%b", x.name, speaker, x.k); end
      end
      $display("check %s: time=%h ringing=%b snoozed=%b set_err=%b speaker=%b",
               x.name, cur, ringing, snoozed, set_err, speaker);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] h1, input logic [3:0] h0, input logic [2:0] m1, input logic [3:0] m0);
    t_h1 = h1; t_h0 = h0; t_m1 = m1; t_m0 = m0;
    set_time = 1'b1;
    cyc();
    set_time = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [1:0] h1, input logic [3:0] h0,
                    input logic [2:0] m1, input logic [3:0] m0);
    alarm_idx = idx; a_h1 = h1; a_h0 = h0; a_m1 = m1; a_m0 = m0;
    alarm_wr = 1'b1;
    cyc();
    alarm_wr = 1'b0;
  endtask

  // n minute advances (two enable pulses each); returns just after the final advancing edge.
  task automatic adv(input int n);
    for (int i = 0; i < 2 * n; i++) begin
      enable = 1'b1;
      cyc();
      enable = 1'b0;
      if (i != 2 * n - 1) cyc();
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; set_time = 1'b0; alarm_wr = 1'b0;
    snooze = 1'b0; dismiss = 1'b0; alarm_en = 4'b0000; alarm_idx = 3'd0;
    t_h1 = '0; t_h0 = '0; t_m1 = '0; t_m0 = '0;
    a_h1 = '0; a_h0 = '0; a_m1 = '0; a_m0 = '0;
    cyc();
    cyc();
    chk("reset", MT | MR | MS | ME | MK, tm(0, 0), 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Midnight wrap
    load(2'd2, 4'd3, 3'd5, 4'd9);
    chk("load_2359", MT | ME, tm(23, 59), 4'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1; cyc(); enable = 1'b0;
    chk("half_tick", MT, tm(23, 59), 4'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    enable = 1'b1; cyc(); enable = 1'b0;
    chk("wrap_0000", MT | MR | ME, tm(0, 0), 4'b0, 1'b0, 1'b0, 1'b0);

    // Slot 2 rings at 07:00 with a divided tone
    wr(3'd2, 2'd0, 4'd7, 3'd0, 4'd0);
    chk("wr_slot2", ME, '0, 4'b0, 1'b0, 1'b0, 1'b0);
    alarm_en = 4'b0100;
    load(2'd0, 4'd6, 3'd5, 4'd9);
    chk("load_0659", MT | MR, tm(6, 59), 4'b0, 1'b0, 1'b0, 1'b0);
    adv(1);
    chk("ring_0700", MT | MR | MS | MK, tm(7, 0), 4'b0100, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("tone_%0d", k), MK, '0, 4'b0, 1'b0, 1'b0, (k >= 4 && k < 8) ? 1'b1 : 1'b0);
    end

    // Snooze and re-ring after 5 minutes
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snooze", MR | MS | MK, '0, 4'b0000, 1'b1, 1'b0, 1'b0);
    adv(4);
    chk("snooze_4min", MT | MR | MS, tm(7, 4), 4'b0000, 1'b1, 1'b0, 1'b0);
    adv(1);
    chk("rering", MT | MR | MS | MK, tm(7, 5), 4'b0100, 1'b0, 1'b0, 1'b0);

    // Unattended timeout after 3 minutes
    adv(2);
    chk("ring_2min", MT | MR, tm(7, 7), 4'b0100, 1'b0, 1'b0, 1'b0);
    adv(1);
    chk("timeout", MT | MR | MS | MK, tm(7, 8), 4'b0000, 1'b0, 1'b0, 1'b0);

    // snooze+dismiss together: dismiss wins
    load(2'd0, 4'd6, 3'd5, 4'd9);
    adv(1);
    chk("ring_again", MR, '0, 4'b0100, 1'b0, 1'b0, 1'b0);
    snooze = 1'b1; dismiss = 1'b1; cyc(); snooze = 1'b0; dismiss = 1'b0;
    chk("snz_dis", MR | MS | MK, '0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Disarming the only ringing slot stops it
    load(2'd0, 4'd6, 3'd5, 4'd9);
    adv(1);
    chk("ring_3rd", MR, '0, 4'b0100, 1'b0, 1'b0, 1'b0);
    alarm_en = 4'b0000; cyc(); alarm_en = 4'b0100;
    chk("disarm", MR | MS, '0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Rejected loads and writes
    load(2'd2, 4'd4, 3'd0, 4'd0);
    chk("bad_2400", MT | ME, tm(7, 0), 4'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("err_clear", MT | ME, tm(7, 0), 4'b0, 1'b0, 1'b0, 1'b0);
    load(2'd1, 4'd2, 3'd6, 4'd0);
    chk("bad_1260", MT | ME, tm(7, 0), 4'b0, 1'b0, 1'b1, 1'b0);
    wr(3'd2, 2'd0, 4'd7, 3'd0, 4'hA);
    chk("bad_wr", ME, '0, 4'b0, 1'b0, 1'b1, 1'b0);
    load(2'd0, 4'd6, 3'd5, 4'd9);
    chk("good_load", MT | ME, tm(6, 59), 4'b0, 1'b0, 1'b0, 1'b0);
    adv(1);
    chk("slot_kept", MT | MR, tm(7, 0), 4'b0100, 1'b0, 1'b0, 1'b0);
    wr(3'd5, 2'd0, 4'd6, 3'd0, 4'd0);
    chk("idx5_ign", ME | MR, '0, 4'b0100, 1'b0, 1'b0, 1'b0);
    wr(3'd2, 2'd0, 4'd8, 3'd0, 4'd0);
    chk("wr_ringing", ME | MR, '0, 4'b0100, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc();

    // Reset mid-ring, then a load onto an alarm time must not ring
    reset = 1'b0; cyc(); reset = 1'b1;
    chk("mid_reset", MT | MR | MS | ME | MK, tm(0, 0), 4'b0000, 1'b0, 1'b0, 1'b0);
    wr(3'd0, 2'd0, 4'd9, 3'd3, 4'd0);
    alarm_en = 4'b0001;
    load(2'd0, 4'd9, 3'd3, 4'd0);
    chk("load_no_ring", MT | MR, tm(9, 30), 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("still_quiet", MR | MS, '0, 4'b0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
      $fatal(1, "scoreboard did not drain");
    end
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
